round_key_sequencer: RTL



---
 rtl/round_key_sequencer_if.sv | 31 +++
 rtl/round_key_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/round_key_sequencer_if.sv
// Round key stream between the AES-128 key schedule and the round engine.
//
// Signals:
//   rk_valid  source -> sink  rk_data / rk_round are valid
//   rk_ready  sink -> source  sink accepts the key when rk_valid && rk_ready
//   rk_round  source -> sink  index 0..10 of the presented round key
//   rk_data   source -> sink  128-bit round key, bits [127:96] are word 0
//
// Modports:
//   master  key schedule side (drives valid/round/data)
//   slave   round engine side (drives ready)
interface round_key_sequencer_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;

    modport master (
        output rk_valid,
        output rk_round,
        output rk_data,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_round,
        input  rk_data,
        output rk_ready
    );
endinterface

// File: rtl/round_key_sequencer.sv
// Iterative AES-128 key schedule.
//
// Latches a 128-bit cipher key on an accepted start and streams the 11 round
// keys (round 0 = cipher key ... round 10) over a valid/ready interface, one
// expansion step per accepted handshake. SubWord uses four combinational
// forward S-box lookups.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       request expansion of cipher_key; only honoured when idle
//   cipher_key  128-bit key, sampled on the accepted start cycle
//   busy        high while round keys are being emitted
//   done        one-cycle pulse after round 10 has been accepted
//   rk          round key stream (master side)
module round_key_sequencer (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [127:0]                 cipher_key,
    output logic                         busy,
    output logic                         done,
    round_key_sequencer_if.master        rk
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bits [8*(255-x)+7 -: 8]; 8*(255-x)+7 == {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] value;
        case (i)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [127:0] next_key;
    logic [31:0]  temp_word;
    logic [31:0]  n0, n1, n2, n3;
    logic         handshake;

    // One expansion step: key for round (round_q + 1) derived from key_q.
    always_comb begin
        temp_word = sub_word({key_q[23:0], key_q[31:24]})
                  ^ {rcon(round_q + 4'd1), 24'h000000};
        n0        = key_q[127:96] ^ temp_word;
        n1        = key_q[95:64]  ^ n0;
        n2        = key_q[63:32]  ^ n1;
        n3        = key_q[31:0]   ^ n2;
        next_key  = {n0, n1, n2, n3};
    end

    assign handshake = (state_q == EMIT) && rk.rk_ready;

    // NOTE: every signal written here gets a default first so that paths
    // which do not assign it cannot infer a latch.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = cipher_key;
                    round_d = 4'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    // All outputs come straight from registers.
    assign busy        = (state_q == EMIT);
    assign done        = done_q;
    assign rk.rk_valid = (state_q == EMIT);
    assign rk.rk_round = round_q;
    assign rk.rk_data  = key_q;

endmodule
